// File: rtl/raster_pkg.sv
// raster_pkg: shared state encoding and default widths for the raster engine.
package raster_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, CALC, FLUSH} raster_state_t;
    localparam int DEF_XW        = 12;
    localparam int DEF_YW        = 12;
    localparam int DEF_MAX_EXTRA = 3;
endpackage

// File: rtl/raster_wrap_cnt.sv
// raster_wrap_cnt: counter stepping on en, returning to 0 after reaching limit.
module raster_wrap_cnt #(
    parameter int W = 12
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         wrap
);
    assign wrap = en && value == limit;
    always_ff @(posedge clk) begin
        if (rst || clr)
            value <= '0;
        else if (en)
            value <= wrap ? '0 : value + W'(1);
    end
endmodule

// File: rtl/raster_engine.sv
// raster_engine: frame raster sequencer running prime, output and flush rows.
// Define RASTER_ENGINE_ABORT_EN to add the abort input that kills a frame.
module raster_engine
    import raster_pkg::*;
#(
    parameter int XW        = DEF_XW,
    parameter int YW        = DEF_YW,
    parameter int MAX_EXTRA = DEF_MAX_EXTRA
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [XW-1:0]                  cfg_width,
    input  logic [YW-1:0]                  cfg_height,
    input  logic [$clog2(MAX_EXTRA+1)-1:0] cfg_pre,
    input  logic [$clog2(MAX_EXTRA+1)-1:0] cfg_post,
    input  logic                           pix_ready,
    output logic                           pix_valid,
    output logic [XW-1:0]                  pix_x,
    output logic [YW-1:0]                  pix_y,
    output logic                           row_start,
    output logic                           frame_done,
    output logic                           idle
`ifdef RASTER_ENGINE_ABORT_EN
    ,
    input  logic                           abort
`endif
);
    localparam int PW = $clog2(MAX_EXTRA + 1);

    raster_state_t state;
    logic [XW-1:0] width_q, x_val;
    logic [YW-1:0] height_q, row_val, row_limit;
    logic [PW-1:0] pre_q, post_q;
    logic          x_en, x_wrap, row_wrap, kill;

`ifdef RASTER_ENGINE_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif

    assign x_en = state == PRIME || state == FLUSH || (state == CALC && pix_ready);

    // one row counter serves all three phases; it returns to 0 at each phase end
    always_comb row_limit = state == PRIME ? YW'(pre_q) - YW'(1) :
                            state == CALC  ? height_q - YW'(1) :
                                             YW'(post_q) - YW'(1);

    raster_wrap_cnt #(.W(XW)) u_x (
        .clk(clk), .rst(rst), .clr(kill), .en(x_en),
        .limit(width_q - XW'(1)), .value(x_val), .wrap(x_wrap)
    );

    raster_wrap_cnt #(.W(YW)) u_row (
        .clk(clk), .rst(rst), .clr(kill), .en(x_wrap),
        .limit(row_limit), .value(row_val), .wrap(row_wrap)
    );

    assign pix_x = x_val;
    assign pix_y = pix_valid ? row_val : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            pix_valid  <= 1'b0;
            row_start  <= 1'b0;
            frame_done <= 1'b0;
            idle       <= 1'b1;
        end else if (kill) begin
            state      <= IDLE;
            pix_valid  <= 1'b0;
            row_start  <= 1'b0;
            frame_done <= 1'b0;
            idle       <= 1'b1;
        end else begin
            row_start  <= x_wrap;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start && cfg_width != '0 && cfg_height != '0) begin
                    width_q   <= cfg_width;
                    height_q  <= cfg_height;
                    pre_q     <= cfg_pre;
                    post_q    <= cfg_post;
                    state     <= cfg_pre != '0 ? PRIME : CALC;
                    pix_valid <= cfg_pre == '0;
                    row_start <= 1'b1;
                    idle      <= 1'b0;
                end
                PRIME: if (row_wrap) begin
                    state     <= CALC;
                    pix_valid <= 1'b1;
                end
                CALC: if (row_wrap) begin
                    state      <= post_q != '0 ? FLUSH : IDLE;
                    pix_valid  <= 1'b0;
                    row_start  <= post_q != '0;
                    frame_done <= post_q == '0;
                    idle       <= post_q == '0;
                end
                FLUSH: if (row_wrap) begin
                    state      <= IDLE;
                    row_start  <= 1'b0;
                    frame_done <= 1'b1;
                    idle       <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
